// File: rtl/ram_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one shared RAM port: one access per two cycles.
// Build option ARBITER_ROUND_ROBIN_EN: round-robin tie-break; otherwise fixed data priority with starvation limit.
module ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_request,
  input  logic [31:0] inst_address,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  input  logic        data_request,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  input  logic [3:0]  data_select,
  output logic        data_valid,
  output logic [31:0] data_read_data,
  output logic        ram_chip_enable,
  output logic        ram_read_enable,
  output logic        ram_write_enable,
  output logic [31:0] ram_read_address,
  output logic [31:0] ram_write_address,
  output logic [31:0] ram_write_data,
  output logic [3:0]  ram_write_select,
  input  logic [31:0] ram_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic        write_q;
  logic        inst_valid_q;
  logic        data_valid_q;
  logic [31:0] inst_data_q;
  logic [31:0] data_rdata_q;
  logic        pick_inst_d;
  logic        grant_inst_d;
  logic        grant_data_d;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_grant_inst_q;

  // On a tie the port that did not win last time goes next.
  assign pick_inst_d = inst_request && (!data_request || !last_grant_inst_q);
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q;

  assign pick_inst_d = inst_request && (!data_request || (starve_q == LIMIT));
`endif

  assign grant_inst_d = (state_q == IDLE) && pick_inst_d;
  assign grant_data_d = (state_q == IDLE) && data_request && !pick_inst_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      write_q      <= 1'b0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_grant_inst_q <= 1'b0;
`else
      starve_q <= '0;
`endif
    end else begin
      inst_valid_q <= (state_q == GRANT_INST);
      data_valid_q <= (state_q == GRANT_DATA);
      case (state_q)
        IDLE: begin
          if (grant_inst_d) begin
            state_q <= GRANT_INST;
            addr_q  <= inst_address;
            write_q <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
          end else if (grant_data_d) begin
            state_q <= GRANT_DATA;
            addr_q  <= data_address;
            write_q <= data_write;
            sel_q   <= data_select;
            wdata_q <= data_write_data;
          end
`ifdef ARBITER_ROUND_ROBIN_EN
          if (grant_inst_d) begin
            last_grant_inst_q <= 1'b1;
          end else if (grant_data_d) begin
            last_grant_inst_q <= 1'b0;
          end
`else
          // Counts data wins that overtook a waiting fetch; never passes the limit.
          if (!inst_request || grant_inst_d) begin
            starve_q <= '0;
          end else if (grant_data_d && (starve_q != LIMIT)) begin
            starve_q <= starve_q + 4'd1;
          end
`endif
        end
        GRANT_INST: begin
          inst_data_q <= ram_read_data;
          state_q     <= IDLE;
        end
        GRANT_DATA: begin
          if (!write_q) begin
            data_rdata_q <= ram_read_data;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Enables are gated by reset directly so a reset landing mid-grant cannot commit a store.
  assign ram_chip_enable   = !reset && (state_q != IDLE);
  assign ram_read_enable   = ram_chip_enable && !((state_q == GRANT_DATA) && write_q);
  assign ram_write_enable  = !reset && (state_q == GRANT_DATA) && write_q;
  assign ram_read_address  = addr_q;
  assign ram_write_address = addr_q;
  assign ram_write_data    = wdata_q;
  assign ram_write_select  = sel_q;

  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign data_valid     = data_valid_q;
  assign data_read_data = data_rdata_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a word-addressed RAM model (combinational read, negedge write).
module tb_ram_arbiter;

  localparam logic [31:0] PORT_I = 32'd73;
  localparam logic [31:0] PORT_D = 32'd68;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_request;
  logic [31:0] inst_address;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        data_request;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [3:0]  data_select;
  logic        data_valid;
  logic [31:0] data_read_data;
  logic        ram_chip_enable;
  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [31:0] ram_read_address;
  logic [31:0] ram_write_address;
  logic [31:0] ram_write_data;
  logic [3:0]  ram_write_select;
  logic [31:0] ram_read_data;
  logic        busy;

  logic [31:0] mem [0:255];
  logic [31:0] order_q[$];
  logic [31:0] inst_q[$];
  logic [31:0] data_q[$];
  logic [31:0] last_load;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .inst_request(inst_request), .inst_address(inst_address),
    .inst_valid(inst_valid), .inst_data(inst_data),
    .data_request(data_request), .data_write(data_write),
    .data_address(data_address), .data_write_data(data_write_data),
    .data_select(data_select), .data_valid(data_valid),
    .data_read_data(data_read_data),
    .ram_chip_enable(ram_chip_enable), .ram_read_enable(ram_read_enable),
    .ram_write_enable(ram_write_enable), .ram_read_address(ram_read_address),
    .ram_write_address(ram_write_address), .ram_write_data(ram_write_data),
    .ram_write_select(ram_write_select), .ram_read_data(ram_read_data),
    .busy(busy)
  );

  assign ram_read_data = mem[ram_read_address[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // RAM model: the only process that writes mem.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'h11111111;
    mem[8'h12] = 32'h22222222;
    mem[8'h20] = 32'hAABBCCDD;
    mem[8'h21] = 32'h0BADF00D;
    mem[8'h30] = 32'hCAFEF00D;
    forever begin
      @(negedge clock);
      if (ram_write_enable) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_write_select[b]) mem[ram_write_address[9:2]][8*b +: 8] = ram_write_data[8*b +: 8];
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a port presents a completion.
  initial begin
    forever begin
      @(negedge clock);
      if (inst_valid && data_valid) begin
        checks++;
        failures++;
        $display("FAIL both_valid: got both ports valid expected at most one at %0t", $time);
      end
      if (inst_valid) begin
        if (order_q.size() == 0 || inst_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst_valid: got inst_valid=1 expected no response at %0t", $time);
        end else begin
          chk("grant_order", PORT_I, order_q.pop_front());
          chk("inst_data", inst_data, inst_q.pop_front());
        end
      end
      if (data_valid) begin
        if (order_q.size() == 0 || data_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_data_valid: got data_valid=1 expected no response at %0t", $time);
        end else begin
          chk("grant_order", PORT_D, order_q.pop_front());
          chk("data_read_data", data_read_data, data_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    inst_request = 1'b0;
    inst_address = '0;
    data_request = 1'b0;
    data_write = 1'b0;
    data_address = '0;
    data_write_data = '0;
    data_select = '0;
    last_load = '0;
    tick(2);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_data_valid", data_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_data_read_data", data_read_data, 32'h0);
    chk1("rst_ram_ce", ram_chip_enable, 1'b0);
    reset = 1'b0;
    tick(1);

    // Single fetch: address on the RAM one cycle after sampling, data the cycle after.
    inst_request = 1'b1;
    inst_address = 32'h40;
    order_q.push_back(PORT_I);
    inst_q.push_back(32'hDEADBEEF);
    tick(1);
    chk("fetch_ram_addr", ram_read_address, 32'h40);
    chk1("fetch_ram_ce", ram_chip_enable, 1'b1);
    chk1("fetch_ram_re", ram_read_enable, 1'b1);
    chk1("fetch_ram_we", ram_write_enable, 1'b0);
    inst_request = 1'b0;
    tick(1);
    chk1("fetch_valid_latency", inst_valid, 1'b1);
    tick(1);
    chk1("fetch_valid_pulse", inst_valid, 1'b0);

    // Partial store then reload of the same word.
    data_request = 1'b1;
    data_write = 1'b1;
    data_address = 32'h80;
    data_select = 4'b0011;
    data_write_data = 32'h12345678;
    order_q.push_back(PORT_D);
    data_q.push_back(last_load);
    tick(1);
    chk1("store_ram_we", ram_write_enable, 1'b1);
    chk1("store_ram_re", ram_read_enable, 1'b0);
    chk("store_ram_addr", ram_write_address, 32'h80);
    chk("store_ram_sel", {28'h0, ram_write_select}, 32'h3);
    data_request = 1'b0;
    tick(2);
    chk("store_mem_word", mem[8'h20], 32'hAABB5678);
    data_request = 1'b1;
    data_write = 1'b0;
    order_q.push_back(PORT_D);
    data_q.push_back(32'hAABB5678);
    last_load = 32'hAABB5678;
    tick(1);
    data_request = 1'b0;
    tick(2);

    // Both ports requesting continuously for ten grants.
    inst_address = 32'h40;
    data_address = 32'h84;
    data_write = 1'b0;
    for (int g = 0; g < 10; g++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      if (g % 2 == 0) begin
`else
      if (g % 5 == 4) begin
`endif
        order_q.push_back(PORT_I);
        inst_q.push_back(32'hDEADBEEF);
      end else begin
        order_q.push_back(PORT_D);
        data_q.push_back(32'h0BADF00D);
        last_load = 32'h0BADF00D;
      end
    end
    inst_request = 1'b1;
    data_request = 1'b1;
    tick(19);
    inst_request = 1'b0;
    data_request = 1'b0;
    tick(3);
    chk("contention_drained", order_q.size(), 32'h0);

    // Held fetch request, new address each valid cycle.
    inst_request = 1'b1;
    inst_address = 32'h40;
    order_q.push_back(PORT_I);
    inst_q.push_back(32'hDEADBEEF);
    order_q.push_back(PORT_I);
    inst_q.push_back(32'h11111111);
    order_q.push_back(PORT_I);
    inst_q.push_back(32'h22222222);
    tick(1);
    chk1("b2b_busy0", busy, 1'b1);
    tick(1);
    chk1("b2b_busy1", busy, 1'b0);
    inst_address = 32'h44;
    tick(1);
    chk1("b2b_busy2", busy, 1'b1);
    chk("b2b_ram_addr", ram_read_address, 32'h44);
    tick(1);
    chk1("b2b_busy3", busy, 1'b0);
    inst_address = 32'h48;
    tick(1);
    chk1("b2b_busy4", busy, 1'b1);
    inst_request = 1'b0;
    tick(1);
    chk1("b2b_busy5", busy, 1'b0);
    tick(1);
    chk1("b2b_idle", busy, 1'b0);

    // Reset arriving during a store grant aborts it.
    data_request = 1'b1;
    data_write = 1'b1;
    data_address = 32'hC0;
    data_select = 4'b1111;
    data_write_data = 32'h0;
    tick(1);
    data_request = 1'b0;
    reset = 1'b1;
    #1;
    chk1("abort_ram_we", ram_write_enable, 1'b0);
    chk1("abort_ram_ce", ram_chip_enable, 1'b0);
    tick(1);
    reset = 1'b0;
    last_load = '0;
    chk1("abort_data_valid", data_valid, 1'b0);
    chk("abort_data_read_data", data_read_data, 32'h0);
    chk("abort_inst_data", inst_data, 32'h0);
    chk1("abort_busy", busy, 1'b0);
    chk("abort_mem_word", mem[8'h30], 32'hCAFEF00D);
    tick(3);

    chk("order_q_empty", order_q.size(), 32'h0);
    chk("inst_q_empty", inst_q.size(), 32'h0);
    chk("data_q_empty", data_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
